// File: rtl/tmr_pkg.sv
// tmr_pkg: shared state and fault-mask encodings for the TMR vote controller
package tmr_pkg;
  localparam logic [1:0] ST_NORMAL   = 2'd0;
  localparam logic [1:0] ST_DEGRADED = 2'd1;
  localparam logic [1:0] ST_FAILED   = 2'd2;
  localparam logic [2:0] MASK_NONE   = 3'b000;
  localparam logic [2:0] MASK_ALL    = 3'b111;
endpackage

// File: rtl/majority_vote_word.sv
// majority_vote_word: bitwise 2-of-3 vote plus per-channel disagreement flags
module majority_vote_word #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] maj,
  output logic [2:0]       mis
);
  assign maj = (a & b) | (a & c) | (b & c);
  assign mis = {c != maj, b != maj, a != maj};
endmodule

// File: rtl/tmr_vote_controller.sv
// tmr_vote_controller: TMR voter with mismatch tracking, channel retirement and failure drain
module tmr_vote_controller
  import tmr_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int FAULT_THRESH = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ch_a,
  input  logic [WIDTH-1:0] ch_b,
  input  logic [WIDTH-1:0] ch_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_corr,
  output logic             out_err,
  output logic [2:0]       fault_mask,
  output logic [1:0]       state,
  input  logic             clr_faults
);
  localparam logic [CNT_W-1:0] THR = CNT_W'(FAULT_THRESH);
  logic [WIDTH-1:0] maj, pair_x, pair_y, w_data, data_q, data_d;
  logic [2:0] mis, hits, mask_q, mask_d;
  logic [1:0] state_q, state_d;
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d, cnt_n;
  logic [CNT_W-1:0] pair_q, pair_d, pair_n;
  logic xfer, pair_mis, multi, w_corr, w_err;
  logic valid_q, valid_d, corr_q, corr_d, err_q, err_d;
  majority_vote_word #(.WIDTH(WIDTH)) u_vote (.a(ch_a), .b(ch_b), .c(ch_c), .maj(maj), .mis(mis));
  assign in_ready = !valid_q || out_ready;
  assign xfer     = in_valid && in_ready;
  // healthy pair: lower-index survivor is X and supplies the data word
  assign pair_x   = mask_q[0] ? ch_b : ch_a;
  assign pair_y   = mask_q[2] ? ch_b : ch_c;
  assign pair_mis = pair_x != pair_y;
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_n[i] = mis[i] ? (cnt_q[i] == THR ? THR : cnt_q[i] + CNT_W'(1)) : '0;
      hits[i]  = cnt_n[i] == THR;
    end
    pair_n = pair_mis ? (pair_q == THR ? THR : pair_q + CNT_W'(1)) : '0;
    multi  = (hits[0] & hits[1]) | (hits[0] & hits[2]) | (hits[1] & hits[2]);
  end
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    pair_d  = pair_q;
    if (clr_faults) begin
      state_d = ST_NORMAL;
      mask_d  = MASK_NONE;
      cnt_d   = '0;
      pair_d  = '0;
    end else if (xfer && state_q == ST_NORMAL) begin
      state_d = multi ? ST_FAILED : |hits ? ST_DEGRADED : ST_NORMAL;
      mask_d  = multi ? MASK_ALL : hits;
      cnt_d   = |hits ? '0 : cnt_n;
    end else if (xfer && state_q == ST_DEGRADED) begin
      state_d = pair_n == THR ? ST_FAILED : ST_DEGRADED;
      mask_d  = pair_n == THR ? MASK_ALL : mask_q;
      pair_d  = pair_n == THR ? '0 : pair_n;
    end
  end
  always_comb begin
    w_data  = state_q == ST_NORMAL ? maj : state_q == ST_DEGRADED ? pair_x : '0;
    w_corr  = state_q == ST_NORMAL && |mis;
    w_err   = state_q == ST_FAILED || (state_q == ST_DEGRADED && pair_mis);
    valid_d = xfer || (valid_q && !out_ready);
    data_d  = xfer ? w_data : data_q;
    corr_d  = xfer ? w_corr : corr_q;
    err_d   = xfer ? w_err : err_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_NORMAL;
      mask_q  <= MASK_NONE;
      cnt_q   <= '0;
      pair_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      corr_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      pair_q  <= pair_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      corr_q  <= corr_d;
      err_q   <= err_d;
    end
  end
  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_corr   = corr_q;
  assign out_err    = err_q;
  assign fault_mask = mask_q;
  assign state      = state_q;
endmodule

// File: tb/tb_tmr_vote_controller.sv
// tb_tmr_vote_controller: directed plus random stimulus against a behavioural TMR model
module tb_tmr_vote_controller;
  localparam int T = 4;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, clr_faults = 1'b0;
  logic [7:0] ch_a = '0, ch_b = '0, ch_c = '0;
  logic in_ready, out_valid, out_corr, out_err;
  logic [7:0] out_data;
  logic [2:0] fault_mask;
  logic [1:0] state;
  int errors = 0, checks = 0;
  int m_state, m_cnt[3], m_pair;
  bit [2:0] m_mask;
  bit m_valid, m_corr, m_err;
  bit [7:0] m_data;
  always #5 clk = ~clk;
  tmr_vote_controller dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ch_a(ch_a), .ch_b(ch_b), .ch_c(ch_c), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_corr(out_corr), .out_err(out_err),
    .fault_mask(fault_mask), .state(state), .clr_faults(clr_faults)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_state = 0; m_mask = 0; m_pair = 0; m_valid = 0; m_data = 0; m_corr = 0; m_err = 0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
  endtask
  task automatic check_outputs();
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_data", out_data, m_data);
      chk("out_corr", out_corr, m_corr);
      chk("out_err", out_err, m_err);
    end
    chk("state", state, m_state);
    chk("fault_mask", fault_mask, m_mask);
  endtask
  task automatic step(input bit v, input bit [7:0] a, input bit [7:0] b, input bit [7:0] c,
                      input bit ordy, input bit clr);
    bit [7:0] ch[3], maj, x, y;
    bit rdy, xf;
    int ones, hit_n, hit_i, healthy[$];
    in_valid = v; ch_a = a; ch_b = b; ch_c = c; out_ready = ordy; clr_faults = clr;
    #1;
    ch = '{a, b, c};
    rdy = !m_valid || ordy;
    xf = v && rdy;
    chk("in_ready", in_ready, rdy);
    for (int k = 0; k < 8; k++) begin
      ones = int'(a[k]) + int'(b[k]) + int'(c[k]);
      maj[k] = ones >= 2;
    end
    for (int i = 0; i < 3; i++) if (!m_mask[i]) healthy.push_back(i);
    x = healthy.size() >= 2 ? ch[healthy[0]] : 8'h00;
    y = healthy.size() >= 2 ? ch[healthy[1]] : 8'h00;
    if (xf) begin
      m_valid = 1;
      if (m_state == 0) begin
        m_data = maj; m_err = 0; m_corr = (a != maj) || (b != maj) || (c != maj);
      end else if (m_state == 1) begin
        m_data = x; m_err = (x != y); m_corr = 0;
      end else begin
        m_data = 0; m_err = 1; m_corr = 0;
      end
    end else if (ordy) m_valid = 0;
    if (clr) begin
      m_state = 0; m_mask = 0; m_pair = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else if (xf && m_state == 0) begin
      hit_n = 0; hit_i = 0;
      for (int i = 0; i < 3; i++) begin
        m_cnt[i] = (ch[i] != maj) ? ((m_cnt[i] + 1 > T) ? T : m_cnt[i] + 1) : 0;
        if (m_cnt[i] == T) begin hit_n++; hit_i = i; end
      end
      if (hit_n >= 2) begin m_state = 2; m_mask = 3'b111; end
      else if (hit_n == 1) begin m_state = 1; m_mask = 3'(1 << hit_i); end
      if (hit_n > 0) foreach (m_cnt[i]) m_cnt[i] = 0;
    end else if (xf && m_state == 1) begin
      m_pair = (x != y) ? ((m_pair + 1 > T) ? T : m_pair + 1) : 0;
      if (m_pair == T) begin m_state = 2; m_mask = 3'b111; m_pair = 0; end
    end
    @(negedge clk);
    check_outputs();
  endtask
  initial begin
    bit [7:0] base, w[3];
    int bad, r;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_corr", out_corr, 1'b0);
    chk("rst_out_err", out_err, 1'b0);
    chk("rst_fault_mask", fault_mask, 3'b000);
    chk("rst_state", state, 2'd0);
    rst_n = 1'b1;
    // clean stream
    step(1, 8'h5A, 8'h5A, 8'h5A, 1, 0);
    chk("clean_5a", out_data, 8'h5A);
    step(1, 8'hFF, 8'hFF, 8'hFF, 1, 0);
    step(1, 8'h00, 8'h00, 8'h00, 1, 0);
    // single upset, cleared by a clean word
    step(1, 8'h3C, 8'h3D, 8'h3C, 1, 0);
    chk("upset_corr", out_corr, 1'b1);
    chk("upset_data", out_data, 8'h3C);
    step(1, 8'h3C, 8'h3C, 8'h3C, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 8'h00, 8'h01, 8'h00, 1, 0);
    chk("no_retire_after_clear", state, 2'd0);
    step(1, 8'h00, 8'h00, 8'h00, 1, 0);
    // channel B retirement
    for (int i = 0; i < 4; i++) step(1, 8'h00, 8'h01, 8'h00, 1, 0);
    chk("retire_mask", fault_mask, 3'b010);
    chk("retire_state", state, 2'd1);
    step(1, 8'h11, 8'h77, 8'h22, 1, 0);
    chk("degraded_data", out_data, 8'h11);
    chk("degraded_err", out_err, 1'b1);
    // drive A/C disagreement to failure
    for (int i = 0; i < 3; i++) step(1, 8'h11, 8'h00, 8'h22, 1, 0);
    chk("failed_state", state, 2'd2);
    step(1, 8'hAA, 8'hAA, 8'hAA, 1, 0);
    chk("failed_data", out_data, 8'h00);
    chk("failed_err", out_err, 1'b1);
    step(0, 8'h00, 8'h00, 8'h00, 1, 1);
    chk("clr_state", state, 2'd0);
    // backpressure
    step(1, 8'h21, 8'h21, 8'h21, 0, 0);
    step(1, 8'h22, 8'h22, 8'h22, 0, 0);
    step(1, 8'h23, 8'h22, 8'h22, 0, 0);
    chk("bp_hold", out_data, 8'h21);
    step(1, 8'h24, 8'h24, 8'h24, 1, 0);
    step(1, 8'h25, 8'h25, 8'h25, 1, 0);
    step(0, 8'h00, 8'h00, 8'h00, 1, 0);
    // random phase
    bad = 1;
    for (int n = 0; n < 400; n++) begin
      if (n % 25 == 0) bad = $urandom_range(0, 2);
      base = 8'($urandom);
      w = '{base, base, base};
      r = $urandom_range(0, 9);
      if (r >= 5 && r <= 7) w[bad] = base ^ 8'($urandom_range(1, 255));
      else if (r == 8) w[$urandom_range(0, 2)] = base ^ 8'($urandom_range(1, 255));
      else if (r == 9) w = '{8'($urandom), 8'($urandom), 8'($urandom)};
      step($urandom_range(0, 9) < 8, w[0], w[1], w[2], $urandom_range(0, 3) != 0,
           $urandom_range(0, 39) == 0);
    end
    // async reset mid-stream with counter B at 3
    step(0, 8'h00, 8'h00, 8'h00, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 8'h40, 8'h41, 8'h40, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_state", state, 2'd0);
    chk("async_mask", fault_mask, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 8'h40, 8'h41, 8'h40, 1, 0);
    chk("post_reset_counters", state, 2'd0);
    step(1, 8'h40, 8'h41, 8'h40, 1, 0);
    chk("post_reset_retire", fault_mask, 3'b010);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tmr_vote_controller.md
Name: tmr_vote_controller

Overview:
- Sequencing and fault-management controller for a triple-modular-redundant (TMR) word path.
- Accepts three redundant WIDTH-bit channel words under valid/ready handshake and drives one registered, voted output word under the same handshake.
- Bitwise 2-of-3 vote while all channels are healthy.
- Counts consecutive per-channel mismatches; retires a persistently faulty channel (degraded 2-channel compare), then declares total failure.

Parameters:
- WIDTH, 8, channel/output word width.
- FAULT_THRESH, 4, consecutive mismatching transfers before a channel (or pair) is declared faulty; legal range 1..255.
- CNT_W, 8, mismatch counter width; must hold FAULT_THRESH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  channel words valid.
- in_ready  out  1  controller can accept.
- ch_a  in  WIDTH  channel A word (index 0).
- ch_b  in  WIDTH  channel B word (index 1).
- ch_c  in  WIDTH  channel C word (index 2).
- out_valid  out  1  out_data/out_corr/out_err valid.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  voted word.
- out_corr  out  1  at least one channel was out-voted (corrected) in this word.
- out_err  out  1  uncorrectable word (degraded disagreement or FAILED).
- fault_mask  out  3  retired channels, bit0=A, bit1=B, bit2=C.
- state  out  2  0=NORMAL, 1=DEGRADED, 2=FAILED.
- clr_faults  in  1  synchronous single-cycle pulse: return to NORMAL.

Behaviour:
- Reset (rst_n=0, async): out_valid=0, out_data=0, out_corr=0, out_err=0, fault_mask=0, state=NORMAL, all counters 0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Transfer = in_valid && in_ready.
  - Results register on the transfer edge; latency 1 cycle; full throughput, 1 word/cycle.
- Output hold: while out_valid && !out_ready, out_data/out_corr/out_err are held stable.
- out_valid: cleared when out_ready && no new transfer.
- NORMAL:
  - out_data = bitwise maj(a,b,c); out_err=0; out_corr = any channel != voted word.
  - Per-channel counter, updated on transfer only: +1 if that channel != voted, else cleared; saturates at FAULT_THRESH.
  - Exactly one counter reaching FAULT_THRESH: set its fault_mask bit, state -> DEGRADED, all counters cleared.
  - Two or more counters reaching FAULT_THRESH in the same cycle: fault_mask=3'b111, state -> FAILED.
- DEGRADED:
  - Masked channel ignored; healthy pair = lower index X, higher index Y.
  - X==Y: out_data=X, out_err=0, pair counter cleared.
  - X!=Y: out_data=X, out_err=1, pair counter +1.
  - out_corr=0.
  - Pair counter reaching FAULT_THRESH: fault_mask=3'b111, state -> FAILED.
- FAILED:
  - Transfers still accepted (drain, no stall); out_data=0, out_err=1, out_corr=0.
  - Leaves only via clr_faults or reset.
- Decision timing: the state/mask update and the word that triggers it register on the same edge. That word is voted under the old state; the next word uses the new state.
- clr_faults:
  - Priority over all counter/state updates: state=NORMAL, fault_mask=0, counters=0 next edge.
  - A coincident transfer is still registered, voted under the pre-clear state, but does not touch counters.
  - Output register and handshake are unaffected.
- in_valid with !in_ready: inputs ignored, counters unchanged.

Decomposition:
- Package tmr_pkg: state encoding constants (ST_NORMAL=2'd0, ST_DEGRADED=2'd1, ST_FAILED=2'd2) and mask constants (MASK_NONE=3'b000, MASK_ALL=3'b111).
- Sub-module majority_vote_word: purely combinational, parameter WIDTH, inputs a/b/c, output bitwise majority and 3-bit per-channel mismatch vector.
- Top contains the FSM, counters and output register.

Test Plan:
- Clean stream: a=b=c=8'h5A, 8'hFF, 8'h00, out_ready=1 -> out_data 5A,FF,00 one cycle after each transfer; out_corr=0, out_err=0, state=0.
- Single upset: a=8'h3C, b=8'h3D, c=8'h3C once -> out_data=3C, out_corr=1; counter B=1, then cleared by the next clean word; fault_mask stays 0.
- Channel retirement: b=8'h01 vs a=c=8'h00 for 4 consecutive transfers -> 4th word out_data=00; after it, fault_mask=3'b010, state=1.
  - Then a=8'h11, c=8'h22 -> out_data=11, out_err=1.
- Failure path: from DEGRADED, 4 consecutive A/C disagreements -> state=2, fault_mask=3'b111; next word -> out_data=00, out_err=1.
  - Then pulse clr_faults -> state=0, mask=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 after the first transfer; out_data held; no counter change; release -> words delivered in order, none lost.
- Async reset mid-stream: drop rst_n while out_valid=1 and counter B=3 -> out_valid=0 immediately; after release, counters 0, state=0.
